// File: rtl/dlx_debug_pkg.sv
// Shared types and default sizing for the DLX debug trace buffer.
package dlx_debug_pkg;

  typedef enum bit [2:0] {
    TR_IDLE    = 3'd0,
    TR_ARMED   = 3'd1,
    TR_POST    = 3'd2,
    TR_FROZEN  = 3'd3,
    TR_READOUT = 3'd4
  } dbg_trace_state_t;

  localparam int unsigned DBG_TRACE_DEPTH = 16;
  localparam int unsigned DBG_TRACE_POST  = 8;

endpackage

// File: rtl/dbg_trace_ram.sv
// DEPTH x DBG_W trace storage: one write port, one registered read port.
// Storage is never reset; only the read data register is.
module dbg_trace_ram #(
  parameter int unsigned DBG_W = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [DBG_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [DBG_W-1:0] o_rd_data
);

  logic [DBG_W-1:0] r_mem [DEPTH];
  logic [DBG_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dlx_debug_trace_buffer.sv
// Circular debug trace capture: arm, trigger, post-trigger fill, freeze, oldest-first readout.
// Optional DBG_TRACE_FILTER_EN: only write samples differing from the last written one.
module dlx_debug_trace_buffer
  import dlx_debug_pkg::*;
#(
  parameter int unsigned DBG_W     = 32,
  parameter int unsigned DEPTH     = DBG_TRACE_DEPTH,
  parameter int unsigned POST_TRIG = DBG_TRACE_POST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm_i,
  input  logic                       trig_i,
  input  logic [DBG_W-1:0]           sample_i,
  input  logic                       sample_vld_i,
  output logic                       rd_valid_o,
  output logic [DBG_W-1:0]           rd_data_o,
  input  logic                       rd_ready_i,
  output logic                       rd_last_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       wrapped_o,
  output logic [2:0]                 state_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dbg_trace_state_t r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]    r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]    r_post_cnt, w_post_cnt_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_wrapped, w_wrapped_nxt;
  logic             r_rd_valid, w_rd_valid_nxt;
  logic             r_rd_last, w_rd_last_nxt;

  logic             w_capture;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic             w_hs;

  assign w_capture = (r_state == TR_ARMED) || (r_state == TR_POST);
  assign w_hs      = r_rd_valid & rd_ready_i;

`ifdef DBG_TRACE_FILTER_EN
  // Last written sample, used to suppress consecutive duplicates.
  logic [DBG_W-1:0] r_last_sample;
  logic             r_have_last;

  assign w_wr_en = w_capture & sample_vld_i & (~r_have_last | (sample_i != r_last_sample));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_sample <= '0;
      r_have_last   <= 1'b0;
    end else if ((r_state == TR_IDLE) && arm_i) begin
      r_have_last   <= 1'b0;
    end else if (w_wr_en) begin
      r_last_sample <= sample_i;
      r_have_last   <= 1'b1;
    end
  end
`else
  assign w_wr_en = w_capture & sample_vld_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= TR_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_wrapped  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_post_cnt <= w_post_cnt_nxt;
      r_count    <= w_count_nxt;
      r_wrapped  <= w_wrapped_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_post_cnt_nxt = r_post_cnt;
    w_count_nxt    = r_count;
    w_wrapped_nxt  = r_wrapped;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_last_nxt  = r_rd_last;
    w_rd_en        = 1'b0;
    w_rd_addr      = r_rd_ptr + AW'(1);

    // Capture writes share bookkeeping across ARMED and POST.
    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (r_count == CW'(DEPTH)) begin
        w_wrapped_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end

    case (r_state)
      TR_IDLE: begin
        if (arm_i) begin
          w_state_nxt   = TR_ARMED;
          w_wr_ptr_nxt  = '0;
          w_count_nxt   = '0;
          w_wrapped_nxt = 1'b0;
        end
      end
      TR_ARMED: begin
        if (trig_i) begin
          w_state_nxt    = (POST_TRIG == 0) ? TR_FROZEN : TR_POST;
          w_post_cnt_nxt = CW'(POST_TRIG);
        end
      end
      TR_POST: begin
        if (w_wr_en) begin
          w_post_cnt_nxt = r_post_cnt - CW'(1);
          if (r_post_cnt == CW'(1)) begin
            w_state_nxt = TR_FROZEN;
          end
        end
      end
      TR_FROZEN: begin
        // Oldest entry sits at wr_ptr once the ring has wrapped.
        w_rd_addr    = r_wrapped ? r_wr_ptr : '0;
        w_rd_ptr_nxt = w_rd_addr;
        w_rd_en      = 1'b1;
        if (r_count == '0) begin
          w_state_nxt = TR_IDLE;
        end else begin
          w_state_nxt    = TR_READOUT;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = (r_count == CW'(1));
        end
      end
      TR_READOUT: begin
        if (w_hs) begin
          w_rd_ptr_nxt  = r_rd_ptr + AW'(1);
          w_count_nxt   = r_count - CW'(1);
          w_rd_en       = (r_count != CW'(1));
          w_rd_last_nxt = (r_count == CW'(2));
          if (r_count == CW'(1)) begin
            w_state_nxt    = TR_IDLE;
            w_rd_valid_nxt = 1'b0;
            w_rd_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = TR_IDLE;
      end
    endcase
  end

  dbg_trace_ram #(
    .DBG_W (DBG_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (sample_i),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (rd_data_o)
  );

  assign rd_valid_o = r_rd_valid;
  assign rd_last_o  = r_rd_last;
  assign count_o    = r_count;
  assign wrapped_o  = r_wrapped;
  assign state_o    = 3'(r_state);

endmodule

// File: tb/tb_dlx_debug_trace_buffer.sv
// Bench for dlx_debug_trace_buffer: instance 0 uses POST_TRIG=8, instance 1 uses POST_TRIG=0.
module tb_dlx_debug_trace_buffer;
  import dlx_debug_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  logic [1:0]         arm, trig, vld, rdy;
  logic [1:0][DW-1:0] smp;
  wire  [1:0]         w_rv, w_last, w_wrapped;
  wire  [1:0][DW-1:0] w_rdata;
  wire  [1:0][CW-1:0] w_count;
  wire  [1:0][2:0]    w_state;

  dlx_debug_trace_buffer #(.DBG_W(DW), .DEPTH(DEPTH), .POST_TRIG(8)) u_dut0 (
    .clk(clk), .rst(rst), .arm_i(arm[0]), .trig_i(trig[0]), .sample_i(smp[0]),
    .sample_vld_i(vld[0]), .rd_valid_o(w_rv[0]), .rd_data_o(w_rdata[0]),
    .rd_ready_i(rdy[0]), .rd_last_o(w_last[0]), .count_o(w_count[0]),
    .wrapped_o(w_wrapped[0]), .state_o(w_state[0])
  );

  dlx_debug_trace_buffer #(.DBG_W(DW), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut1 (
    .clk(clk), .rst(rst), .arm_i(arm[1]), .trig_i(trig[1]), .sample_i(smp[1]),
    .sample_vld_i(vld[1]), .rd_valid_o(w_rv[1]), .rd_data_o(w_rdata[1]),
    .rd_ready_i(rdy[1]), .rd_last_o(w_last[1]), .count_o(w_count[1]),
    .wrapped_o(w_wrapped[1]), .state_o(w_state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one capture session at a time (phase 0 idle, 1 armed, 2 post, 3 frozen).
  int          phase = 0;
  int          cur = 0;
  int          post_left = 0;
  logic [31:0] m_q[$];

  typedef struct {
    int               kind;  // 0 = single step, 1 = readout
    int               d;
    bit               a;
    bit               v;
    bit               t;
    logic [31:0]      val;
    dbg_trace_state_t st;
    int               cnt;
    bit               wr;
    int               mode;
  } vec_t;

  vec_t tbl[$];

  function automatic int post_of(int d);
    return (d == 0) ? 8 : 0;
  endfunction

  function automatic int m_count();
    return (m_q.size() > DEPTH) ? DEPTH : m_q.size();
  endfunction

  function automatic dbg_trace_state_t exp_state();
    case (phase)
      1:       return TR_ARMED;
      2:       return TR_POST;
      3:       return TR_FROZEN;
      default: return TR_IDLE;
    endcase
  endfunction

  function automatic vec_t mk_step(int d, bit a, bit v, bit t, logic [31:0] val,
                                   dbg_trace_state_t st, int cnt);
    vec_t r;
    r.kind = 0; r.d = d; r.a = a; r.v = v; r.t = t; r.val = val;
    r.st = st; r.cnt = cnt; r.wr = 1'b0; r.mode = 0;
    return r;
  endfunction

  function automatic vec_t mk_ro(int d, int mode);
    vec_t r;
    r = mk_step(d, 1'b0, 1'b0, 1'b0, 32'h0, TR_IDLE, 0);
    r.kind = 1; r.mode = mode;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(int d, bit a, bit v, bit t, logic [31:0] val);
    bit w;
    if (phase == 0) begin
      if (a) begin
        phase = 1; cur = d; m_q.delete();
      end
    end else if (d == cur && (phase == 1 || phase == 2)) begin
      w = v;
`ifdef DBG_TRACE_FILTER_EN
      if (w && m_q.size() > 0 && m_q[m_q.size()-1] == val) w = 1'b0;
`endif
      if (w) m_q.push_back(val);
      if (phase == 1) begin
        if (t) begin
          if (post_of(d) == 0) phase = 3;
          else begin phase = 2; post_left = post_of(d); end
        end
      end else if (w) begin
        post_left--;
        if (post_left == 0) phase = 3;
      end
    end
  endtask

  task automatic step(int d, bit a, bit v, bit t, logic [31:0] val);
    arm[d] = a; vld[d] = v; trig[d] = t; smp[d] = val;
    tick();
    arm[d] = 1'b0; vld[d] = 1'b0; trig[d] = 1'b0;
    model_step(d, a, v, t, val);
  endtask

  task automatic chk_model(int d, string nm);
    chk({nm, "_state"},   32'(w_state[d]),   32'(exp_state()));
    chk({nm, "_count"},   32'(w_count[d]),   32'(m_count()));
    chk({nm, "_wrapped"}, 32'(w_wrapped[d]), 32'(m_q.size() > DEPTH));
  endtask

  // Drains a frozen DUT; mode 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic readout(int d, int mode);
    int n, first, idx;
    bit r;
    n = m_count();
    first = m_q.size() - n;
    idx = 0;
    tick();
    if (n == 0) begin
      chk("ro_empty_state", 32'(w_state[d]), 32'(TR_IDLE));
      chk("ro_empty_valid", 32'(w_rv[d]), 32'd0);
      tick();
      chk("ro_empty_valid2", 32'(w_rv[d]), 32'd0);
      phase = 0;
      return;
    end
    chk("ro_wrapped", 32'(w_wrapped[d]), 32'(m_q.size() > DEPTH));
    for (int c = 0; c < 400 && idx < n; c++) begin
      chk("ro_valid", 32'(w_rv[d]), 32'd1);
      chk("ro_data",  w_rdata[d], m_q[first + idx]);
      chk("ro_last",  32'(w_last[d]), 32'(idx == n - 1));
      chk("ro_count", 32'(w_count[d]), 32'(n - idx));
      chk("ro_state", 32'(w_state[d]), 32'(TR_READOUT));
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 4 == 0) || (c % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy[d] = r;
      tick();
      rdy[d] = 1'b0;
      if (r) idx++;
    end
    if (idx < n) chk("ro_timeout", 32'(idx), 32'(n));
    chk("ro_end_valid", 32'(w_rv[d]), 32'd0);
    chk("ro_end_state", 32'(w_state[d]), 32'(TR_IDLE));
    chk("ro_end_count", 32'(w_count[d]), 32'd0);
    phase = 0;
  endtask

  task automatic run_seq(int d, int n, int trig_at, string nm);
    for (int i = 1; i <= n && phase != 3; i++) begin
      step(d, 1'b0, 1'b1, (i == trig_at), 32'(i));
      chk_model(d, nm);
    end
  endtask

  initial begin
    rst = 1'b0;
    arm = '0; trig = '0; vld = '0; rdy = '0; smp = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_state",   32'(w_state[d]),   32'(TR_IDLE));
      chk("rst_count",   32'(w_count[d]),   32'd0);
      chk("rst_valid",   32'(w_rv[d]),      32'd0);
      chk("rst_last",    32'(w_last[d]),    32'd0);
      chk("rst_wrapped", 32'(w_wrapped[d]), 32'd0);
      chk("rst_data",    w_rdata[d],        32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic capture with post-trigger fill, arm/trig ignored where irrelevant.
    tbl.push_back(mk_step(0, 1'b0, 1'b0, 1'b1, 32'h0, TR_IDLE, 0));
    tbl.push_back(mk_step(0, 1'b1, 1'b0, 1'b0, 32'h0, TR_ARMED, 0));
    for (int i = 1; i <= 14; i++)
      tbl.push_back(mk_step(0, (i == 3), 1'b1, (i == 6), 32'(i),
                            (i < 6) ? TR_ARMED : ((i < 14) ? TR_POST : TR_FROZEN), i));
    tbl.push_back(mk_ro(0, 1));
    // POST_TRIG=0: trigger on third sample, then trigger with nothing captured.
    tbl.push_back(mk_step(1, 1'b1, 1'b0, 1'b0, 32'h0,  TR_ARMED, 0));
    tbl.push_back(mk_step(1, 1'b0, 1'b1, 1'b0, 32'hA,  TR_ARMED, 1));
    tbl.push_back(mk_step(1, 1'b0, 1'b1, 1'b0, 32'hB,  TR_ARMED, 2));
    tbl.push_back(mk_step(1, 1'b0, 1'b1, 1'b1, 32'hC,  TR_FROZEN, 3));
    tbl.push_back(mk_ro(1, 0));
    tbl.push_back(mk_step(1, 1'b1, 1'b0, 1'b0, 32'h0,  TR_ARMED, 0));
    tbl.push_back(mk_step(1, 1'b0, 1'b0, 1'b1, 32'h0,  TR_FROZEN, 0));
    tbl.push_back(mk_ro(1, 0));

    foreach (tbl[i]) begin
      if (tbl[i].kind == 1) begin
        readout(tbl[i].d, tbl[i].mode);
      end else begin
        step(tbl[i].d, tbl[i].a, tbl[i].v, tbl[i].t, tbl[i].val);
        chk($sformatf("vec%0d_state", i),   32'(w_state[tbl[i].d]),   32'(tbl[i].st));
        chk($sformatf("vec%0d_count", i),   32'(w_count[tbl[i].d]),   32'(tbl[i].cnt));
        chk($sformatf("vec%0d_wrapped", i), 32'(w_wrapped[tbl[i].d]), 32'(tbl[i].wr));
      end
    end

    // Wrap: samples 1..40, trigger on 30, freeze after 38.
    step(0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_seq(0, 40, 30, "wrap");
    chk("wrap_frozen",  32'(w_state[0]),   32'(TR_FROZEN));
    chk("wrap_count",   32'(w_count[0]),   32'd16);
    chk("wrap_flag",    32'(w_wrapped[0]), 32'd1);
    readout(0, 0);

    // Duplicate samples, POST_TRIG=0.
    step(1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1, 1'b0, 1'b1, 1'b0, 32'd5);
    step(1, 1'b0, 1'b1, 1'b0, 32'd5);
    step(1, 1'b0, 1'b1, 1'b0, 32'd5);
    step(1, 1'b0, 1'b1, 1'b0, 32'd7);
    step(1, 1'b0, 1'b1, 1'b0, 32'd7);
    step(1, 1'b0, 1'b1, 1'b1, 32'd9);
`ifdef DBG_TRACE_FILTER_EN
    chk("dup_count", 32'(w_count[1]), 32'd3);
`else
    chk("dup_count", 32'(w_count[1]), 32'd6);
`endif
    chk("dup_state", 32'(w_state[1]), 32'(TR_FROZEN));
    readout(1, 0);

    // Asynchronous reset during post-trigger fill, then a clean re-arm.
    step(0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_seq(0, 6, 4, "pre_rst");
    chk("pre_rst_in_post", 32'(w_state[0]), 32'(TR_POST));
    #3 rst = 1'b0;
    #1;
    chk("arst_state",   32'(w_state[0]),   32'(TR_IDLE));
    chk("arst_count",   32'(w_count[0]),   32'd0);
    chk("arst_valid",   32'(w_rv[0]),      32'd0);
    chk("arst_wrapped", 32'(w_wrapped[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    phase = 0;
    step(0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_seq(0, 20, 2, "rearm");
    readout(0, 0);

    // Randomized sessions on both instances against the model.
    for (int it = 0; it < 24; it++) begin
      int d, k, s;
      bit v, t;
      logic [31:0] val;
      d = it % 2;
      k = $urandom_range(0, 40);
      s = 0;
      step(d, 1'b1, 1'b0, 1'b0, 32'h0);
      chk_model(d, "rnd_arm");
      while (phase != 3 && s < 300) begin
        v = ($urandom_range(0, 3) != 0);
        val = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom;
        t = (s >= k) && ($urandom_range(0, 2) == 0);
        step(d, 1'b0, v, t, val);
        chk_model(d, "rnd_step");
        s++;
      end
      if (phase != 3) begin
        chk("rnd_freeze", 32'(phase), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        phase = 0;
      end else begin
        readout(d, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
